// File: rtl/ryuki_datatypes_pkg.sv
// Shared trace datatypes: the completed tracker payload and the timestamped record
// built from it, sized for the default collector configuration.
package ryuki_datatypes;

  localparam int TRACE_ADDR_WIDTH   = 32;
  localparam int TRACE_DATA_WIDTH   = 32;
  localparam int TRACE_NUM_CHANNELS = 4;
  localparam int TRACE_TS_WIDTH     = 32;

  function automatic int trace_ch_width(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

  localparam int TRACE_CH_WIDTH = trace_ch_width(TRACE_NUM_CHANNELS);

  typedef struct packed {
    logic [TRACE_ADDR_WIDTH-1:0] addr;
    logic [TRACE_DATA_WIDTH-1:0] data;
  } trace_output;

  // Field order is the bit layout that trace_collector uses on trace_data_o.
  typedef struct packed {
    logic [TRACE_CH_WIDTH-1:0] channel;
    logic [TRACE_TS_WIDTH-1:0] timestamp;
    trace_output               payload;
  } trace_record;

endpackage

// File: rtl/trace_collector_fifo.sv
// Show-ahead FIFO of trace records; a push into a full FIFO is only accepted
// when a pop happens in the same cycle.
module trace_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LEVEL = (PW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/trace_collector.sv
// Collects single-cycle trace strobes from several trackers, timestamps them into
// per-channel pending slots and drains one slot per cycle round-robin into a FIFO.
module trace_collector
  import ryuki_datatypes::*;
#(
  parameter int  ADDR_WIDTH   = TRACE_ADDR_WIDTH,
  parameter int  DATA_WIDTH   = TRACE_DATA_WIDTH,
  parameter int  NUM_CHANNELS = TRACE_NUM_CHANNELS,
  parameter int  DEPTH        = 16,
  parameter int  TS_WIDTH     = TRACE_TS_WIDTH,
  localparam int CH_WIDTH     = trace_ch_width(NUM_CHANNELS),
  localparam int OUT_WIDTH    = ADDR_WIDTH + DATA_WIDTH,
  localparam int REC_WIDTH    = CH_WIDTH + TS_WIDTH + OUT_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [NUM_CHANNELS-1:0]           ch_valid,
  input  logic [NUM_CHANNELS*OUT_WIDTH-1:0] ch_data,
  output logic                              trace_data_ready,
  output logic [REC_WIDTH-1:0]              trace_data_o,
  input  logic                              trace_data_ack,
  output logic [15:0]                       drop_count,
  output logic [$clog2(DEPTH):0]            fifo_level
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } payload_t;

  typedef struct packed {
    logic [CH_WIDTH-1:0] channel;
    logic [TS_WIDTH-1:0] timestamp;
    payload_t            payload;
  } record_t;

  logic [TS_WIDTH-1:0]     ts;
  logic [NUM_CHANNELS-1:0] pend_valid;
  record_t                 pend_rec [NUM_CHANNELS];
  logic [CH_WIDTH-1:0]     rr_ptr;
  logic [CH_WIDTH-1:0]     drain_idx;
  logic [NUM_CHANNELS-1:0] drain_sel;
  logic [NUM_CHANNELS-1:0] accept;
  logic [NUM_CHANNELS-1:0] drop_vec;
  logic [16:0]             drop_sum;
  logic                    drain_hit;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  record_t                 head;
  int                      cand;

  assign pop  = !fifo_empty && trace_data_ack;
  assign push = drain_hit && (!fifo_full || pop);

  // First pending slot at or after rr_ptr, wrapping around the channel count.
  always_comb begin
    drain_hit = 1'b0;
    drain_idx = '0;
    drain_sel = '0;
    cand      = 0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_CHANNELS;
      if (!drain_hit && pend_valid[cand]) begin
        drain_hit       = 1'b1;
        drain_idx       = CH_WIDTH'(cand);
        drain_sel[cand] = 1'b1;
      end
    end
  end

  // A slot being drained this cycle may take a new record; otherwise a full slot drops it.
  always_comb begin
    accept   = '0;
    drop_vec = '0;
    drop_sum = {1'b0, drop_count};
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      accept[i]   = ch_valid[i] && enable && (!pend_valid[i] || (push && drain_sel[i]));
      drop_vec[i] = ch_valid[i] && enable && !accept[i];
      drop_sum    = drop_sum + 17'(drop_vec[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts         <= '0;
      pend_valid <= '0;
      rr_ptr     <= '0;
      drop_count <= '0;
    end else begin
      if (enable) ts <= ts + TS_WIDTH'(1);
      pend_valid <= (pend_valid & ~(drain_sel & {NUM_CHANNELS{push}})) | accept;
      if (push) begin
        rr_ptr <= (drain_idx == CH_WIDTH'(NUM_CHANNELS-1)) ? '0 : drain_idx + CH_WIDTH'(1);
      end
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (accept[i]) pend_rec[i] <= {CH_WIDTH'(i), ts, ch_data[i*OUT_WIDTH +: OUT_WIDTH]};
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .T     (record_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pend_rec[drain_idx]),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign trace_data_ready = !fifo_empty;
  assign trace_data_o     = head;

endmodule

// File: tb/tb_trace_collector.sv
// Directed bench for trace_collector: a default instance plus a 4-bit timestamp
// instance sharing the same stimulus for the wrap scenario.
module tb_trace_collector;
  import ryuki_datatypes::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         ack = 1'b0;
  logic [3:0]   ch_valid = '0;
  logic [255:0] ch_data = '0;

  logic         ready;
  trace_record  rec_o;
  logic [15:0]  drops;
  logic [4:0]   level;

  logic         ready_w;
  logic [69:0]  rec_w;
  logic [15:0]  drops_w;
  logic [4:0]   level_w;

  int total = 0;
  int bad = 0;
  int ts_model = 0;

  always #5 clk = ~clk;

  trace_collector dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .ch_valid         (ch_valid),
    .ch_data          (ch_data),
    .trace_data_ready (ready),
    .trace_data_o     (rec_o),
    .trace_data_ack   (ack),
    .drop_count       (drops),
    .fifo_level       (level)
  );

  trace_collector #(.TS_WIDTH(4)) dut_w (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .ch_valid         (ch_valid),
    .ch_data          (ch_data),
    .trace_data_ready (ready_w),
    .trace_data_o     (rec_w),
    .trace_data_ack   (ack),
    .drop_count       (drops_w),
    .fifo_level       (level_w)
  );

  task automatic tick();
    @(posedge clk);
    if (enable && !rst) ts_model++;
    #1;
  endtask

  task automatic set_payload(input int ch, input logic [31:0] data);
    ch_data[ch*64 +: 64] = {32'hA000_0000 + 32'(ch), data};
  endtask

  task automatic apply_reset();
    rst = 1'b1; enable = 1'b0; ch_valid = '0; ack = 1'b0; ch_data = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    ts_model = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %0b expected 0", ready); end
    total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    total++; if (drops !== 16'd0) begin bad++; $display("[TB] FAIL reset_drops: got %0d expected 0", drops); end
    total++; if (ready_w !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready_w: got %0b expected 0", ready_w); end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    enable = 1'b1;
    repeat (5) tick();
    set_payload(0, 32'hCAFE_0001);
    ch_valid = 4'b0001;
    tick();
    ch_valid = '0;
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL single_early: got %0b expected 0", ready); end
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready: got %0b expected 1", ready); end
    total++; if (rec_o.channel !== 2'd0) begin bad++; $display("[TB] FAIL single_channel: got %0d expected 0", rec_o.channel); end
    total++; if (rec_o.timestamp !== 32'd5) begin bad++; $display("[TB] FAIL single_ts: got %0d expected 5", rec_o.timestamp); end
    total++; if (rec_o.payload.data !== 32'hCAFE_0001) begin bad++; $display("[TB] FAIL single_data: got %h expected cafe0001", rec_o.payload.data); end
    total++; if (rec_o.payload.addr !== 32'hA000_0000) begin bad++; $display("[TB] FAIL single_addr: got %h expected a0000000", rec_o.payload.addr); end
    total++; if (drops !== 16'd0) begin bad++; $display("[TB] FAIL single_drops: got %0d expected 0", drops); end
    total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL single_level: got %0d expected 1", level); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL single_pop_level: got %0d expected 0", level); end
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL single_pop_ready: got %0b expected 0", ready); end
  endtask

  task automatic test_simultaneous();
    int ts_b;
    apply_reset();
    enable = 1'b1;
    ack = 1'b1;
    tick(); tick();
    for (int ch = 0; ch < 4; ch++) set_payload(ch, 32'h5100 + 32'(ch));
    ch_valid = 4'b1111;
    ts_b = ts_model;
    tick();
    ch_valid = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL burst_ready[%0d]: got %0b expected 1", k, ready); end
      total++; if (rec_o.channel !== 2'(k)) begin bad++; $display("[TB] FAIL burst_channel[%0d]: got %0d expected %0d", k, rec_o.channel, k); end
      total++; if (rec_o.timestamp !== 32'(ts_b)) begin bad++; $display("[TB] FAIL burst_ts[%0d]: got %0d expected %0d", k, rec_o.timestamp, ts_b); end
      total++; if (rec_o.payload.data !== 32'h5100 + 32'(k)) begin bad++; $display("[TB] FAIL burst_data[%0d]: got %h expected %h", k, rec_o.payload.data, 32'h5100 + 32'(k)); end
      tick();
    end
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL burst_empty: got %0b expected 0", ready); end
    set_payload(0, 32'h5200);
    set_payload(3, 32'h5203);
    ch_valid = 4'b1001;
    tick();
    ch_valid = '0;
    tick();
    total++; if (rec_o.channel !== 2'd0 || ready !== 1'b1) begin bad++; $display("[TB] FAIL wrap_first: got ch=%0d rdy=%0b expected ch=0 rdy=1", rec_o.channel, ready); end
    tick();
    total++; if (rec_o.channel !== 2'd3 || ready !== 1'b1) begin bad++; $display("[TB] FAIL wrap_second: got ch=%0d rdy=%0b expected ch=3 rdy=1", rec_o.channel, ready); end
    tick();
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL wrap_empty: got %0b expected 0", ready); end
    ack = 1'b0;
  endtask

  task automatic test_overflow();
    int first_ts;
    apply_reset();
    enable = 1'b1;
    tick();
    first_ts = ts_model;
    for (int k = 0; k < 30; k++) begin
      set_payload(2, 32'(k));
      ch_valid = 4'b0100;
      tick();
    end
    ch_valid = '0;
    total++; if (level !== 5'd16) begin bad++; $display("[TB] FAIL ovf_level: got %0d expected 16", level); end
    total++; if (drops !== 16'd13) begin bad++; $display("[TB] FAIL ovf_drops: got %0d expected 13", drops); end
    ack = 1'b1;
    for (int k = 0; k < 17; k++) begin
      total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL ovf_ready[%0d]: got %0b expected 1", k, ready); end
      total++; if (rec_o.channel !== 2'd2) begin bad++; $display("[TB] FAIL ovf_channel[%0d]: got %0d expected 2", k, rec_o.channel); end
      total++; if (rec_o.timestamp !== 32'(first_ts + k)) begin bad++; $display("[TB] FAIL ovf_ts[%0d]: got %0d expected %0d", k, rec_o.timestamp, first_ts + k); end
      total++; if (rec_o.payload.data !== 32'(k)) begin bad++; $display("[TB] FAIL ovf_data[%0d]: got %0d expected %0d", k, rec_o.payload.data, k); end
      tick();
    end
    total++; if (ready !== 1'b0 || level !== 5'd0) begin bad++; $display("[TB] FAIL ovf_drained: got rdy=%0b lvl=%0d expected rdy=0 lvl=0", ready, level); end
    ack = 1'b0;
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    enable = 1'b1;
    for (int k = 0; k < 17; k++) begin
      set_payload(1, 32'h100 + 32'(k));
      ch_valid = 4'b0010;
      tick();
    end
    ch_valid = '0;
    total++; if (level !== 5'd16) begin bad++; $display("[TB] FAIL full_level: got %0d expected 16", level); end
    total++; if (drops !== 16'd0) begin bad++; $display("[TB] FAIL full_drops: got %0d expected 0", drops); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++; if (level !== 5'd16) begin bad++; $display("[TB] FAIL pushpop_level: got %0d expected 16", level); end
    total++; if (rec_o.payload.data !== 32'h101) begin bad++; $display("[TB] FAIL pushpop_head: got %h expected 101", rec_o.payload.data); end
    ch_valid = 4'b0010;
    tick();
    ch_valid = '0;
    total++; if (drops !== 16'd0) begin bad++; $display("[TB] FAIL pushpop_slot_free: got %0d expected 0", drops); end
    total++; if (level !== 5'd16) begin bad++; $display("[TB] FAIL pushpop_hold: got %0d expected 16", level); end
  endtask

  task automatic test_enable_wrap();
    apply_reset();
    enable = 1'b1;
    ack = 1'b1;
    repeat (12) tick();
    enable = 1'b0;
    ch_valid = 4'b0001;
    repeat (3) tick();
    ch_valid = '0;
    repeat (2) tick();
    total++; if (ready_w !== 1'b0 || level_w !== 5'd0) begin bad++; $display("[TB] FAIL disabled_capture: got rdy=%0b lvl=%0d expected 0 0", ready_w, level_w); end
    total++; if (drops_w !== 16'd0) begin bad++; $display("[TB] FAIL disabled_drops: got %0d expected 0", drops_w); end
    enable = 1'b1;
    set_payload(0, 32'h77);
    ch_valid = 4'b0001;
    tick();
    ch_valid = '0;
    tick();
    total++; if (ready_w !== 1'b1 || rec_w[67:64] !== 4'd12) begin bad++; $display("[TB] FAIL hold_ts: got rdy=%0b ts=%0d expected rdy=1 ts=12", ready_w, rec_w[67:64]); end
    tick();
    ch_valid = 4'b0001;
    tick();
    tick();
    ch_valid = '0;
    total++; if (ready_w !== 1'b1 || rec_w[67:64] !== 4'd15) begin bad++; $display("[TB] FAIL wrap_ts15: got rdy=%0b ts=%0d expected rdy=1 ts=15", ready_w, rec_w[67:64]); end
    tick();
    total++; if (ready_w !== 1'b1 || rec_w[67:64] !== 4'd0) begin bad++; $display("[TB] FAIL wrap_ts0: got rdy=%0b ts=%0d expected rdy=1 ts=0", ready_w, rec_w[67:64]); end
    tick();
    total++; if (ready_w !== 1'b0) begin bad++; $display("[TB] FAIL wrap_empty: got %0b expected 0", ready_w); end
    total++; if (drops_w !== 16'd0) begin bad++; $display("[TB] FAIL wrap_drops: got %0d expected 0", drops_w); end
    ack = 1'b0;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    enable = 1'b1;
    ch_valid = 4'b1111;
    tick();
    ch_valid = 4'b0011;
    tick();
    ch_valid = '0;
    repeat (4) tick();
    total++; if (level !== 5'd5) begin bad++; $display("[TB] FAIL pre_reset_level: got %0d expected 5", level); end
    total++; if (drops !== 16'd1) begin bad++; $display("[TB] FAIL pre_reset_drops: got %0d expected 1", drops); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ready: got %0b expected 0", ready); end
    total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL midrst_level: got %0d expected 0", level); end
    total++; if (drops !== 16'd0) begin bad++; $display("[TB] FAIL midrst_drops: got %0d expected 0", drops); end
    @(posedge clk); #1;
    rst = 1'b0;
    ts_model = 0;
    set_payload(2, 32'hBEEF);
    ch_valid = 4'b0100;
    tick();
    ch_valid = '0;
    tick();
    total++; if (ready !== 1'b1 || rec_o.channel !== 2'd2) begin bad++; $display("[TB] FAIL post_rst_rec: got rdy=%0b ch=%0d expected rdy=1 ch=2", ready, rec_o.channel); end
    total++; if (rec_o.timestamp !== 32'd0) begin bad++; $display("[TB] FAIL post_rst_ts: got %0d expected 0", rec_o.timestamp); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_full_push_pop();
    test_enable_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trace_collector.md
TRACE_COLLECTOR -- requirements
Module: trace_collector

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width of the carried trace payload.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width of the carried trace payload.
REQ-003 SHALL have parameter NUM_CHANNELS, default 4: number of tracker input channels (2..16).
REQ-004 SHALL have parameter DEPTH, default 16: output FIFO depth in records (power of two, >=2).
REQ-005 SHALL have parameter TS_WIDTH, default 32: timestamp counter width.
REQ-006 SHALL have port clk  input  1: single clock, rising edge.
REQ-007 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-008 SHALL have port enable  input  1: capture enable.
REQ-009 SHALL have port ch_valid  input  NUM_CHANNELS: per-channel single-cycle record strobe; no backpressure.
REQ-010 SHALL have port ch_data  input  NUM_CHANNELS x trace_output: per-channel completed trace payload.
REQ-011 SHALL have port trace_data_ready  output  1: output record valid.
REQ-012 SHALL have port trace_data_o  output  trace_record: head-of-FIFO record.
REQ-013 SHALL have port trace_data_ack  input  1: consumer accepts head record.
REQ-014 SHALL have port drop_count  output  16: saturating count of dropped records.
REQ-015 SHALL have port fifo_level  output  clog2(DEPTH)+1: FIFO occupancy.

Function
REQ-016 SHALL run a TS_WIDTH timestamp counter: +1 per cycle while enable=1, holds while enable=0, wraps from all-ones to 0.
REQ-017 SHALL capture ch_valid[i]&enable into pending slot i with {channel=i, timestamp=current counter value, payload=ch_data[i]} at the same edge.
REQ-018 SHALL ignore ch_valid while enable=0 (no capture, no drop count).
REQ-019 SHALL, when ch_valid[i]&enable arrives while slot i is full and not drained that cycle, discard the new record and increment drop_count, saturating at 16'hFFFF.
REQ-020 SHALL accept a new record into slot i when slot i is drained in the same cycle.
REQ-021 SHALL drain at most one pending slot per cycle into the FIFO, chosen round-robin starting at the channel after the last drained one; pointer resets to channel 0.
REQ-022 SHALL push when fifo_level<DEPTH, or when fifo_level==DEPTH and a pop occurs in the same cycle.
REQ-023 SHALL hold pending slots unchanged while no push is possible.
REQ-024 SHALL assert trace_data_ready iff fifo_level>0 and present the head record combinationally (show-ahead).
REQ-025 SHALL pop on trace_data_ready&trace_data_ack; ack with trace_data_ready=0 has no effect.
REQ-026 SHALL have latency of exactly 2 cycles from ch_valid at cycle N to trace_data_ready at cycle N+2 when the FIFO is empty and no other slot is pending.
REQ-027 SHALL preserve per-channel order; cross-channel order follows drain order.
REQ-028 SHALL update fifo_level by +1 on push, -1 on pop, 0 on both.

Reset
REQ-029 SHALL, on rst=1 at any time, immediately clear the counter to 0, all pending slots, the FIFO pointers, fifo_level, drop_count and the round-robin pointer to 0, and drive trace_data_ready=0.
REQ-030 SHALL discard records in flight at reset; the first capture after rst deasserts carries timestamp 0.

Structure
REQ-031 SHALL declare typedef trace_record (channel id clog2(NUM_CHANNELS) bits, timestamp TS_WIDTH bits, trace_output payload) in the shared ryuki_datatypes package, alongside trace_output.
REQ-032 SHALL implement the FIFO as sub-module trace_fifo (parametrised depth and element type, push/pop/full/empty/level).

Verification
REQ-033 Single record: enable=1, ch_valid=4'b0001 at cycle 5 after reset -> trace_data_ready at cycle 7, channel=0, timestamp=5, drop_count=0.
REQ-034 Simultaneous: ch_valid=4'b1111 in one cycle -> four records out on consecutive cycles, channels 0,1,2,3; a second burst then starts at channel 0 after the pointer has wrapped from 3.
REQ-035 Overflow: DEPTH=16, ack held low, channel 2 strobes every cycle for 30 cycles -> fifo_level=16, slot 2 full, drop_count=13; after ack is released 17 records leave in timestamp order.
REQ-036 Full with simultaneous push/pop: fifo_level=16, slot 1 pending, ack=1 -> level stays 16, slot 1 pushed in the same cycle.
REQ-037 Enable/wrap: TS_WIDTH=4, enable toggled -> timestamp holds while enable=0, 15 wraps to 0, strobes while enable=0 are neither captured nor counted.
REQ-038 Mid-operation reset: rst pulsed with 5 records queued -> trace_data_ready=0 and fifo_level=0 in the same cycle, drop_count=0; the next record carries timestamp 0.
